// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU constants and fetch sequencer state type
// Purpose: datapath width, instruction size, default boot/trap vectors and the
//          fetch_state_t encoding used by fetch_sequencer.
// Ports:   none (package).
package cpu_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;

  localparam logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000;
  localparam logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100;

  typedef enum logic [1:0] {
    BOOT,
    REQUEST,
    WAIT
  } fetch_state_t;

endpackage

// File: rtl/fetch_sequencer_if.sv
// rtl/fetch_sequencer_if.sv - instruction memory request/response bus
// Purpose: groups the imem handshake between fetch_sequencer (master) and the
//          instruction memory (slave). The request address is the program
//          counter output and is not carried on this bus.
// Signals: req_valid  master->slave  fetch request
//          req_ready  slave->master  request accepted when valid && ready
//          rsp_valid  slave->master  one-cycle response pulse
//          rsp_data   slave->master  fetched instruction word
interface fetch_sequencer_if;
  import cpu_pkg::*;

  logic                       req_valid;
  logic                       req_ready;
  logic                       rsp_valid;
  logic [INSTR_BYTES*8-1:0]   rsp_data;

  modport master (output req_valid, input req_ready, input rsp_valid, input rsp_data);
  modport slave  (input req_valid, output req_ready, output rsp_valid, output rsp_data);

endinterface

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - one-outstanding instruction fetch sequencer
// Purpose: drives the sibling program_counter (enable_n / load / new_address),
//          issues one imem request at a time from pc_address and returns each
//          fetched word tagged with the address it came from. Branch/jump
//          redirects from execute override everything except reset.
// Optional: PC_CTRL_MISALIGN_TRAP_EN - misaligned redirect targets go to
//          TRAP_VECTOR with a misaligned_trap pulse; otherwise the low target
//          bits are cleared and misaligned_trap stays 0.
// Ports:   clk, reset_n (async active-low)
//          stall, redirect_valid, redirect_target      from decode / execute
//          pc_enable_n, pc_load, pc_new_address        to program_counter
//          pc_address                                  from program_counter
//          imem (fetch_sequencer_if.master)            instruction memory bus
//          instr_valid, instr, instr_pc                to decode
//          misaligned_trap                             redirect trap pulse
module fetch_sequencer #(
  parameter int XLEN = cpu_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_VECTOR = cpu_pkg::RESET_VECTOR
`ifdef PC_CTRL_MISALIGN_TRAP_EN
  ,
  parameter logic [XLEN-1:0] TRAP_VECTOR = cpu_pkg::TRAP_VECTOR
`endif
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       stall,
  input  logic                       redirect_valid,
  input  logic [XLEN-1:0]            redirect_target,
  output logic                       pc_enable_n,
  output logic                       pc_load,
  output logic [XLEN-1:0]            pc_new_address,
  input  logic [XLEN-1:0]            pc_address,
  fetch_sequencer_if.master          imem,
  output logic                       instr_valid,
  output logic [31:0]                instr,
  output logic [XLEN-1:0]            instr_pc,
  output logic                       misaligned_trap
);
  import cpu_pkg::*;

  fetch_state_t    state, state_next;
  logic            kill, kill_next;
  logic [XLEN-1:0] req_pc;
  logic            capture;
  logic            deliver;
  logic [XLEN-1:0] redirect_addr;
  logic            redirect_trap;

  always_comb begin
    redirect_addr = redirect_target & ~XLEN'(INSTR_BYTES - 1);
    redirect_trap = 1'b0;
`ifdef PC_CTRL_MISALIGN_TRAP_EN
    if (redirect_target[1:0] != 2'b00) begin
      redirect_addr = TRAP_VECTOR;
      redirect_trap = 1'b1;
    end
`endif
  end

  always_comb begin
    state_next      = state;
    kill_next       = kill;
    capture         = 1'b0;
    deliver         = 1'b0;
    pc_enable_n     = 1'b1;
    pc_load         = 1'b0;
    pc_new_address  = '0;
    imem.req_valid  = 1'b0;
    misaligned_trap = 1'b0;

    case (state)
      BOOT: begin
        pc_enable_n    = 1'b0;
        pc_load        = 1'b1;
        pc_new_address = RESET_VECTOR;
        state_next     = REQUEST;
      end

      REQUEST: begin
        if (redirect_valid) begin
          pc_enable_n     = 1'b0;
          pc_load         = 1'b1;
          pc_new_address  = redirect_addr;
          misaligned_trap = redirect_trap;
        end else begin
          imem.req_valid = !stall;
          if (!stall && imem.req_ready) begin
            capture    = 1'b1;
            state_next = WAIT;
          end
        end
      end

      WAIT: begin
        if (redirect_valid) begin
          pc_enable_n     = 1'b0;
          pc_load         = 1'b1;
          pc_new_address  = redirect_addr;
          misaligned_trap = redirect_trap;
          // A response landing with the redirect retires the in-flight fetch
          // right here; otherwise its word is still coming and must be dropped.
          if (imem.rsp_valid) begin
            kill_next  = 1'b0;
            state_next = REQUEST;
          end else begin
            kill_next = 1'b1;
          end
        end else if (imem.rsp_valid) begin
          state_next = REQUEST;
          if (kill) begin
            kill_next = 1'b0;
          end else begin
            deliver     = 1'b1;
            pc_enable_n = 1'b0;
          end
        end
      end

      default: state_next = BOOT;
    endcase

    // Reset must reach the program_counter and imem controls immediately,
    // not only after the next clock edge.
    if (!reset_n) begin
      pc_enable_n     = 1'b1;
      pc_load         = 1'b0;
      pc_new_address  = '0;
      imem.req_valid  = 1'b0;
      misaligned_trap = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= BOOT;
      kill        <= 1'b0;
      req_pc      <= '0;
      instr_valid <= 1'b0;
      instr       <= '0;
      instr_pc    <= '0;
    end else begin
      state       <= state_next;
      kill        <= kill_next;
      instr_valid <= deliver;
      if (capture) begin
        req_pc <= pc_address;
      end
      if (deliver) begin
        instr    <= imem.rsp_data;
        instr_pc <= req_pc;
      end
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - self-checking bench for fetch_sequencer
// Purpose: fetch_sequencer with a behavioural program_counter and an imem
//          model of programmable response latency; delivered words are checked
//          against a queue of expected fetch addresses.
// Ports:   none (top-level bench).
module tb_fetch_sequencer;
  import cpu_pkg::*;

`ifdef PC_CTRL_MISALIGN_TRAP_EN
  localparam logic TRAP_EN = 1'b1;
`else
  localparam logic TRAP_EN = 1'b0;
`endif

  typedef struct {
    logic [31:0] target;
    logic [31:0] exp_addr;
    logic        exp_trap;
  } redir_vec_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = '0;
  logic        pc_enable_n;
  logic        pc_load;
  logic [31:0] pc_new_address;
  logic [31:0] pc_address;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        misaligned_trap;

  fetch_sequencer_if imem_bus();

  fetch_sequencer dut (
    .clk(clk), .reset_n(reset_n), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .pc_enable_n(pc_enable_n), .pc_load(pc_load), .pc_new_address(pc_new_address),
    .pc_address(pc_address), .imem(imem_bus),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .misaligned_trap(misaligned_trap)
  );

  always #5 clk = ~clk;

  // program_counter sibling: hold, load, or advance by one instruction
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) pc_address <= 32'h0;
    else if (!pc_enable_n) pc_address <= pc_load ? pc_new_address : pc_address + 32'd4;
  end

  int checks = 0;
  int failures = 0;

  logic        pend, kill_m, ignore_rsp;
  int          cnt, lat;
  logic [31:0] paddr;
  logic [31:0] q_pc[$];
  logic [31:0] req_log[$];
  logic [31:0] del_pc[$];
  logic        obs_en_n, obs_load, obs_req, obs_trap;
  logic [31:0] obs_new;
  redir_vec_t  vecs[5];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'd7) ^ 32'hC0DE_0013;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // One clock cycle: imem model, observe combinational outputs mid-cycle,
  // then check the registered decode interface just after the edge.
  task automatic step();
    logic        rsp_now;
    logic [31:0] rsp_addr;
    logic [31:0] e;
    rsp_now = 1'b0;
    rsp_addr = '0;
    imem_bus.rsp_valid = 1'b0;
    if (pend) begin
      cnt--;
      if (cnt == 0) begin
        rsp_now = 1'b1;
        rsp_addr = paddr;
        pend = 1'b0;
        imem_bus.rsp_valid = 1'b1;
        imem_bus.rsp_data = mem_word(paddr);
      end
    end
    #1;
    obs_en_n = pc_enable_n;
    obs_load = pc_load;
    obs_new  = pc_new_address;
    obs_req  = imem_bus.req_valid;
    obs_trap = misaligned_trap;
    if (rsp_now) begin
      if (!(redirect_valid || kill_m || ignore_rsp)) q_pc.push_back(rsp_addr);
      kill_m = 1'b0;
    end else if (redirect_valid && pend) begin
      kill_m = 1'b1;
    end
    if (imem_bus.req_valid && imem_bus.req_ready) begin
      pend = 1'b1;
      cnt = lat;
      paddr = pc_address;
      req_log.push_back(pc_address);
    end
    @(posedge clk);
    #1;
    if (q_pc.size() == 0) begin
      if (instr_valid) chk("instr_valid_spurious", 32'(instr_valid), 32'h0);
    end else begin
      e = q_pc.pop_front();
      chk("instr_valid", 32'(instr_valid), 32'h1);
      if (instr_valid) begin
        chk("instr_pc", instr_pc, e);
        chk("instr", instr, mem_word(e));
        del_pc.push_back(instr_pc);
      end
    end
  endtask

  task automatic step_redirect(input logic [31:0] t);
    redirect_valid = 1'b1;
    redirect_target = t;
    step();
    redirect_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    pend = 1'b0; kill_m = 1'b0; ignore_rsp = 1'b0; lat = 1; cnt = 0; paddr = '0;
    q_pc.delete(); req_log.delete(); del_pc.delete();
    stall = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
    imem_bus.rsp_valid = 1'b0; imem_bus.req_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_pc_enable_n"}, 32'(pc_enable_n), 32'h1);
    chk({tag, "_pc_load"}, 32'(pc_load), 32'h0);
    chk({tag, "_pc_new_address"}, pc_new_address, 32'h0);
    chk({tag, "_req_valid"}, 32'(imem_bus.req_valid), 32'h0);
    chk({tag, "_instr_valid"}, 32'(instr_valid), 32'h0);
    chk({tag, "_instr"}, instr, 32'h0);
    chk({tag, "_instr_pc"}, instr_pc, 32'h0);
    chk({tag, "_trap"}, 32'(misaligned_trap), 32'h0);
  endtask

  initial begin
    imem_bus.req_ready = 1'b1;
    imem_bus.rsp_valid = 1'b0;
    imem_bus.rsp_data = '0;

    vecs[0] = '{32'h0000_0200, 32'h0000_0200, 1'b0};
    vecs[1] = '{32'h0000_0102, 32'h0000_0100, TRAP_EN};
    vecs[2] = '{32'h0000_0007, TRAP_EN ? 32'h0000_0100 : 32'h0000_0004, TRAP_EN};
    vecs[3] = '{32'hFFFF_FFFD, TRAP_EN ? 32'h0000_0100 : 32'hFFFF_FFFC, TRAP_EN};
    vecs[4] = '{32'h0000_0040, 32'h0000_0040, 1'b0};

    // 1: reset values, BOOT for one cycle, sequential fetch 0x0, 0x4, 0x8
    do_reset();
    chk_reset_outputs("rst");
    reset_n = 1'b1;
    step();
    chk("boot_enable_n", 32'(obs_en_n), 32'h0);
    chk("boot_load", 32'(obs_load), 32'h1);
    chk("boot_new_address", obs_new, 32'h0);
    chk("boot_req", 32'(obs_req), 32'h0);
    step();
    chk("post_boot_load", 32'(obs_load), 32'h0);
    chk("first_req_valid", 32'(obs_req), 32'h1);
    repeat (5) step();
    chk("seq_count", 32'(del_pc.size()), 32'd3);
    if (del_pc.size() == 3) begin
      chk("seq_pc0", del_pc[0], 32'h0);
      chk("seq_pc1", del_pc[1], 32'h4);
      chk("seq_pc2", del_pc[2], 32'h8);
    end

    // 2: imem_req_ready low for 3 cycles holds the request at 0x4
    do_reset();
    reset_n = 1'b1;
    repeat (3) step();
    imem_bus.req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_req_valid", 32'(obs_req), 32'h1);
      chk("hold_pc", pc_address, 32'h4);
    end
    imem_bus.req_ready = 1'b1;
    step();
    chk("hold_issue_addr", req_log[req_log.size()-1], 32'h4);
    step();
    chk("hold_deliver_count", 32'(del_pc.size()), 32'd2);

    // 3: redirect to 0x200 while waiting on 0x8 (latency 3): stale word dropped
    do_reset();
    reset_n = 1'b1;
    repeat (5) step();
    lat = 3;
    step();
    chk("kill_issue_addr", req_log[req_log.size()-1], 32'h8);
    step_redirect(32'h200);
    chk("kill_redirect_load", 32'(obs_load), 32'h1);
    chk("kill_redirect_addr", obs_new, 32'h200);
    step();
    step();
    lat = 1;
    step();
    chk("kill_next_req", req_log[req_log.size()-1], 32'h200);
    step();
    chk("kill_deliver_count", 32'(del_pc.size()), 32'd3);
    if (del_pc.size() == 3) chk("kill_last_pc", del_pc[2], 32'h200);

    // 4: redirect to 0x40 in the same cycle as the response
    do_reset();
    reset_n = 1'b1;
    step();
    step();
    step_redirect(32'h40);
    chk("coin_no_pc_inc", 32'(obs_load), 32'h1);
    repeat (4) step();
    chk("coin_req_count", 32'(req_log.size()), 32'd3);
    if (req_log.size() == 3) begin
      chk("coin_req1", req_log[1], 32'h40);
      chk("coin_req2", req_log[2], 32'h44);
    end
    chk("coin_deliver_count", 32'(del_pc.size()), 32'd2);
    if (del_pc.size() >= 1) chk("coin_first_pc", del_pc[0], 32'h40);

    // 5: stall for 4 cycles in REQUEST, request issues on release
    do_reset();
    reset_n = 1'b1;
    repeat (3) step();
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("stall_req_valid", 32'(obs_req), 32'h0);
      chk("stall_pc", pc_address, 32'h4);
    end
    stall = 1'b0;
    step();
    chk("stall_release_req", 32'(obs_req), 32'h1);
    chk("stall_release_addr", req_log[req_log.size()-1], 32'h4);
    step();

    // 6: redirect targets applied in REQUEST (aligned, misaligned, wrap)
    for (int v = 0; v < 5; v++) begin
      do_reset();
      reset_n = 1'b1;
      step();
      step_redirect(vecs[v].target);
      chk("vec_enable_n", 32'(obs_en_n), 32'h0);
      chk("vec_load", 32'(obs_load), 32'h1);
      chk("vec_new_address", obs_new, vecs[v].exp_addr);
      chk("vec_trap", 32'(obs_trap), 32'(vecs[v].exp_trap));
      chk("vec_req_blocked", 32'(obs_req), 32'h0);
      step();
      chk("vec_issue_addr", pc_address, vecs[v].exp_addr);
      step();
      chk("vec_deliver_count", 32'(del_pc.size()), 32'd1);
      chk("vec_sb_empty", 32'(q_pc.size()), 32'd0);
    end

    // 7: reset during WAIT; the late response arrives in BOOT and is ignored
    do_reset();
    reset_n = 1'b1;
    repeat (3) step();
    lat = 3;
    step();
    step();
    reset_n = 1'b0;
    #1;
    chk_reset_outputs("wait_rst");
    ignore_rsp = 1'b1;
    step();
    chk("rst_held_enable_n", 32'(obs_en_n), 32'h1);
    reset_n = 1'b1;
    step();
    chk("late_rsp_boot_load", 32'(obs_load), 32'h1);
    chk("late_rsp_boot_addr", obs_new, 32'h0);
    ignore_rsp = 1'b0;
    lat = 1;
    step();
    chk("late_rsp_req_addr", req_log[req_log.size()-1], 32'h0);
    step();
    chk("late_rsp_deliver_pc", del_pc[del_pc.size()-1], 32'h0);
    chk("final_sb_empty", 32'(q_pc.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
